// File: rtl/tmr_fault_manager.sv
// TMR fault manager: per-lane mismatch counters, resync req/ack sequencing, lane retirement, fatal latch.
// Latency: counters update on the flag edge; resync_req rises one cycle after a counter reaches THRESH.
// Backpressure: none, err sampled every err_valid cycle; TMR_FAULT_DECAY_EN adds idle-time counter decay.
module tmr_fault_manager #(
    parameter int CNT_W   = 8,
    parameter int THRESH  = 4,
    parameter int TIMEOUT = 255,
    parameter int DECAY   = 1024
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               err_valid,
    input  logic [2:0]         err,
    input  logic               resync_ack,
    input  logic               fatal_clr,
    output logic [2:0]         resync_req,
    output logic               busy,
    output logic               fatal,
    output logic [2:0]         degraded,
    output logic [3*CNT_W-1:0] err_cnt
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_FATAL} state_t;

    localparam int               TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_THR = CNT_W'(THRESH);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

    if (THRESH < 1 || THRESH >= (2 ** CNT_W)) begin : g_bad_thresh
        $error("tmr_fault_manager: THRESH out of range");
    end
    if (TIMEOUT < 1 || DECAY < 1) begin : g_bad_timing
        $error("tmr_fault_manager: TIMEOUT and DECAY must be >= 1");
    end

    state_t           state_q, state_d;
    logic [2:0]       lane_q, lane_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];
    logic [2:0]       deg_q, deg_d;
    logic             busy_q, busy_d;
    logic             fatal_q, fatal_d;

    logic [2:0]       eff;
    logic [2:0]       hit;
    logic [2:0]       over;
    logic [2:0]       clr;
    logic             fatal_evt;

`ifdef TMR_FAULT_DECAY_EN
    localparam int              DCT_W    = $clog2(DECAY + 1);
    localparam logic [DCT_W-1:0] DCT_LAST = DCT_W'(DECAY - 1);
    logic [DCT_W-1:0] dct_q [3];
    logic [DCT_W-1:0] dct_d [3];
`endif

    always_comb begin
        eff       = err_valid ? (err & ~deg_q) : 3'b000;
        // The lane being resynced is expected to disagree; do not charge it.
        hit       = (state_q == S_REQ) ? (eff & ~lane_q) : eff;
        fatal_evt = err_valid && ((err == 3'b111) ||
                    ((|deg_q) && ((eff[0] & eff[1]) | (eff[0] & eff[2]) | (eff[1] & eff[2]))));

        for (int i = 0; i < 3; i++) begin
            over[i]  = (cnt_q[i] >= CNT_THR);
            cnt_d[i] = (hit[i] && (cnt_q[i] != CNT_MAX)) ? cnt_q[i] + 1'b1 : cnt_q[i];
        end

`ifdef TMR_FAULT_DECAY_EN
        for (int i = 0; i < 3; i++) begin
            dct_d[i] = '0;
            if ((state_q != S_FATAL) && !hit[i]) begin
                if (dct_q[i] == DCT_LAST) begin
                    if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - 1'b1;
                end else begin
                    dct_d[i] = dct_q[i] + 1'b1;
                end
            end
        end
`endif

        state_d = state_q;
        lane_d  = lane_q;
        to_d    = to_q;
        deg_d   = deg_q;
        clr     = 3'b000;

        if (fatal_evt) begin
            state_d = S_FATAL;
            lane_d  = 3'b000;
            to_d    = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|over) begin
                        state_d = S_REQ;
                        to_d    = '0;
                        lane_d  = over[0] ? 3'b001 : (over[1] ? 3'b010 : 3'b100);
                    end
                end
                S_REQ: begin
                    // Ack on the expiry edge still counts as a successful resync.
                    if (resync_ack || (to_q == TO_LAST)) begin
                        clr     = lane_q;
                        state_d = S_IDLE;
                        lane_d  = 3'b000;
                        to_d    = '0;
                        if (!resync_ack) deg_d = deg_q | lane_q;
                    end else begin
                        to_d = to_q + 1'b1;
                    end
                end
                S_FATAL: begin
                    if (fatal_clr) begin
                        clr     = 3'b111;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        for (int i = 0; i < 3; i++) begin
            if (clr[i]) cnt_d[i] = '0;
        end

        busy_d  = (state_d != S_IDLE);
        fatal_d = (state_d == S_FATAL);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            lane_q  <= 3'b000;
            to_q    <= '0;
            deg_q   <= 3'b000;
            busy_q  <= 1'b0;
            fatal_q <= 1'b0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            to_q    <= to_d;
            deg_q   <= deg_d;
            busy_q  <= busy_d;
            fatal_q <= fatal_d;
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
        end
    end

`ifdef TMR_FAULT_DECAY_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 3; i++) dct_q[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) dct_q[i] <= dct_d[i];
        end
    end
`endif

    assign resync_req = lane_q;
    assign busy       = busy_q;
    assign fatal      = fatal_q;
    assign degraded   = deg_q;
    assign err_cnt    = {cnt_q[2], cnt_q[1], cnt_q[0]};

endmodule

// File: tb/tb_tmr_fault_manager.sv
// Bench for tmr_fault_manager: directed table, hand-written corner sequences, random vs reference model.
// Build with TMR_FAULT_DECAY_EN to also exercise the idle-decay behaviour.
module tb_tmr_fault_manager;
    localparam int T_CNT_W   = 8;
    localparam int T_THRESH  = 4;
    localparam int T_TIMEOUT = 8;
    localparam int T_DECAY   = 16;
    localparam int T_MAX     = 255;

    logic        clk;
    logic        resetn;
    logic        err_valid;
    logic [2:0]  err;
    logic        resync_ack;
    logic        fatal_clr;
    logic [2:0]  resync_req;
    logic        busy;
    logic        fatal;
    logic [2:0]  degraded;
    logic [23:0] err_cnt;

    tmr_fault_manager #(
        .CNT_W  (T_CNT_W),
        .THRESH (T_THRESH),
        .TIMEOUT(T_TIMEOUT),
        .DECAY  (T_DECAY)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .err_valid (err_valid),
        .err       (err),
        .resync_ack(resync_ack),
        .fatal_clr (fatal_clr),
        .resync_req(resync_req),
        .busy      (busy),
        .fatal     (fatal),
        .degraded  (degraded),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: lane counts as ints, request as a lane index (-1 = none).
    int       m_cnt [3];
    int       m_quiet [3];
    bit [2:0] m_deg;
    int       m_req;
    bit       m_fatal;
    int       m_wait;

    typedef struct {
        bit        ev;
        bit [2:0]  err;
        bit        ack;
        bit        clr;
        bit [2:0]  req;
        bit        busy;
        bit        fatal;
        bit [2:0]  deg;
        bit [23:0] cnt;
    } vec_t;

    vec_t tbl [9];

    int       r;
    bit [2:0] re;
    bit       rev;
    bit       rack;
    bit       rclr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i]   = 0;
            m_quiet[i] = 0;
        end
        m_deg   = 3'b000;
        m_req   = -1;
        m_fatal = 1'b0;
        m_wait  = 0;
    endfunction

    function automatic void model_step(bit ev, bit [2:0] e_in, bit ack, bit clr);
        int  old [3];
        bit  hit [3];
        int  n;
        bit  fevt;
        bit  was_fatal;
        bit  found;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            old[i] = m_cnt[i];
            hit[i] = ev && e_in[i] && !m_deg[i] && (m_req != i);
            if (ev && e_in[i] && !m_deg[i]) n++;
        end
        fevt      = ev && ((e_in == 3'b111) || ((m_deg != 3'b000) && (n >= 2)));
        was_fatal = m_fatal;
        for (int i = 0; i < 3; i++) begin
            if (hit[i] && old[i] < T_MAX) m_cnt[i] = old[i] + 1;
        end
`ifdef TMR_FAULT_DECAY_EN
        for (int i = 0; i < 3; i++) begin
            if (was_fatal || hit[i]) begin
                m_quiet[i] = 0;
            end else begin
                m_quiet[i]++;
                if (m_quiet[i] == T_DECAY) begin
                    m_quiet[i] = 0;
                    if (m_cnt[i] > 0) m_cnt[i]--;
                end
            end
        end
`endif
        if (fevt) begin
            m_fatal = 1'b1;
            m_req   = -1;
            m_wait  = 0;
        end else if (was_fatal) begin
            if (clr) begin
                m_fatal = 1'b0;
                for (int i = 0; i < 3; i++) m_cnt[i] = 0;
            end
        end else if (m_req >= 0) begin
            m_wait++;
            if (ack) begin
                m_cnt[m_req] = 0;
                m_req        = -1;
                m_wait       = 0;
            end else if (m_wait == T_TIMEOUT) begin
                m_deg[m_req] = 1'b1;
                m_cnt[m_req] = 0;
                m_req        = -1;
                m_wait       = 0;
            end
        end else begin
            found = 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (!found && old[i] >= T_THRESH) begin
                    found  = 1'b1;
                    m_req  = i;
                    m_wait = 0;
                end
            end
        end
    endfunction

    task automatic compare_model(input string tag);
        logic [2:0]  exp_req;
        logic [31:0] exp_cnt;
        exp_req = (m_req >= 0) ? 3'(1 << m_req) : 3'b000;
        exp_cnt = 32'((m_cnt[2] << 16) | (m_cnt[1] << 8) | m_cnt[0]);
        chk({tag, ":resync_req"}, 32'(resync_req), 32'(exp_req));
        chk({tag, ":busy"},       32'(busy),       32'((m_req >= 0) || m_fatal));
        chk({tag, ":fatal"},      32'(fatal),      32'(m_fatal));
        chk({tag, ":degraded"},   32'(degraded),   32'(m_deg));
        chk({tag, ":err_cnt"},    32'(err_cnt),    exp_cnt);
    endtask

    task automatic step(input bit ev, input bit [2:0] e_in, input bit ack, input bit clr, input string tag);
        err_valid  = ev;
        err        = e_in;
        resync_ack = ack;
        fatal_clr  = clr;
        @(posedge clk);
        model_step(ev, e_in, ack, clr);
        #1;
        compare_model(tag);
    endtask

    task automatic reset_dut();
        resetn     = 1'b0;
        err_valid  = 1'b0;
        err        = 3'b000;
        resync_ack = 1'b0;
        fatal_clr  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        model_reset();
        compare_model("reset");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Scenario: lane a reaches THRESH, resync acked on the third REQ cycle.
        tbl[0] = '{1'b1, 3'b001, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 24'h000001};
        tbl[1] = '{1'b1, 3'b001, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 24'h000002};
        tbl[2] = '{1'b1, 3'b001, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 24'h000003};
        tbl[3] = '{1'b1, 3'b001, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 24'h000004};
        tbl[4] = '{1'b0, 3'b000, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 3'b000, 24'h000004};
        tbl[5] = '{1'b1, 3'b001, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 3'b000, 24'h000004};
        tbl[6] = '{1'b1, 3'b010, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 3'b000, 24'h000104};
        tbl[7] = '{1'b0, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 24'h000100};
        tbl[8] = '{1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 24'h000100};

        reset_dut();
        chk("reset_req", 32'(resync_req), 32'h0);
        chk("reset_cnt", 32'(err_cnt), 32'h0);
        for (int k = 0; k < 9; k++) begin
            step(tbl[k].ev, tbl[k].err, tbl[k].ack, tbl[k].clr, $sformatf("tbl%0d", k));
            chk($sformatf("tbl%0d_req", k),   32'(resync_req), 32'(tbl[k].req));
            chk($sformatf("tbl%0d_busy", k),  32'(busy),       32'(tbl[k].busy));
            chk($sformatf("tbl%0d_fatal", k), 32'(fatal),      32'(tbl[k].fatal));
            chk($sformatf("tbl%0d_deg", k),   32'(degraded),   32'(tbl[k].deg));
            chk($sformatf("tbl%0d_cnt", k),   32'(err_cnt),    32'(tbl[k].cnt));
        end

        // Lane b times out and is retired.
        reset_dut();
        repeat (4) step(1'b1, 3'b010, 1'b0, 1'b0, "s2");
        step(1'b0, 3'b000, 1'b0, 1'b0, "s2");
        chk("s2_req_on", 32'(resync_req), 32'h2);
        repeat (7) step(1'b0, 3'b000, 1'b0, 1'b0, "s2");
        chk("s2_req_last", 32'(resync_req), 32'h2);
        step(1'b0, 3'b000, 1'b0, 1'b0, "s2");
        chk("s2_deg", 32'(degraded), 32'h2);
        chk("s2_cntb", 32'(err_cnt[15:8]), 32'h0);
        chk("s2_req_off", 32'(resync_req), 32'h0);
        step(1'b1, 3'b010, 1'b0, 1'b0, "s2");
        chk("s2_masked", 32'(err_cnt[15:8]), 32'h0);

        // Loss of majority during REQ, with lane b already degraded.
        repeat (4) step(1'b1, 3'b001, 1'b0, 1'b0, "s4");
        step(1'b0, 3'b000, 1'b0, 1'b0, "s4");
        chk("s4_req", 32'(resync_req), 32'h1);
        step(1'b1, 3'b111, 1'b0, 1'b0, "s4");
        chk("s4_fatal", 32'(fatal), 32'h1);
        chk("s4_req_drop", 32'(resync_req), 32'h0);
        chk("s4_busy", 32'(busy), 32'h1);
        step(1'b0, 3'b000, 1'b0, 1'b1, "s4");
        chk("s4_clr_fatal", 32'(fatal), 32'h0);
        chk("s4_clr_cnt", 32'(err_cnt), 32'h0);
        chk("s4_clr_deg", 32'(degraded), 32'h2);
        step(1'b1, 3'b101, 1'b0, 1'b0, "s4");
        chk("s4_two_live", 32'(fatal), 32'h1);
        step(1'b1, 3'b111, 1'b0, 1'b1, "s4");
        chk("s4_clr_vs_evt", 32'(fatal), 32'h1);
        step(1'b0, 3'b000, 1'b0, 1'b1, "s4");
        chk("s4_clr2", 32'(busy), 32'h0);

        // Lanes a and c cross together: a is served first.
        reset_dut();
        repeat (4) step(1'b1, 3'b101, 1'b0, 1'b0, "s3");
        step(1'b0, 3'b000, 1'b0, 1'b0, "s3");
        chk("s3_first", 32'(resync_req), 32'h1);
        step(1'b0, 3'b000, 1'b1, 1'b0, "s3");
        chk("s3_gap", 32'(resync_req), 32'h0);
        chk("s3_cnt", 32'(err_cnt), 32'h040000);
        step(1'b0, 3'b000, 1'b0, 1'b0, "s3");
        chk("s3_second", 32'(resync_req), 32'h4);
        step(1'b0, 3'b000, 1'b1, 1'b0, "s3");
        chk("s3_done", 32'(err_cnt), 32'h0);

        // Ack on the timeout-expiry edge.
        reset_dut();
        repeat (4) step(1'b1, 3'b100, 1'b0, 1'b0, "s5");
        step(1'b0, 3'b000, 1'b0, 1'b0, "s5");
        repeat (7) step(1'b0, 3'b000, 1'b0, 1'b0, "s5");
        chk("s5_req_held", 32'(resync_req), 32'h4);
        step(1'b0, 3'b000, 1'b1, 1'b0, "s5");
        chk("s5_no_deg", 32'(degraded), 32'h0);
        chk("s5_cnt", 32'(err_cnt), 32'h0);
        chk("s5_idle", 32'(busy), 32'h0);

        // Asynchronous reset in the middle of REQ.
        reset_dut();
        repeat (4) step(1'b1, 3'b001, 1'b0, 1'b0, "s6");
        step(1'b0, 3'b000, 1'b0, 1'b0, "s6");
        chk("s6_req_pre", 32'(resync_req), 32'h1);
        #2 resetn = 1'b0;
        #1;
        chk("s6_req_async", 32'(resync_req), 32'h0);
        chk("s6_busy_async", 32'(busy), 32'h0);
        chk("s6_deg_async", 32'(degraded), 32'h0);
        model_reset();
        #2 resetn = 1'b1;
        @(posedge clk);
        #1;
        compare_model("s6_post");

`ifdef TMR_FAULT_DECAY_EN
        reset_dut();
        repeat (2) step(1'b1, 3'b001, 1'b0, 1'b0, "dec");
        chk("dec_start", 32'(err_cnt[7:0]), 32'd2);
        repeat (15) step(1'b0, 3'b000, 1'b0, 1'b0, "dec");
        chk("dec_15", 32'(err_cnt[7:0]), 32'd2);
        step(1'b0, 3'b000, 1'b0, 1'b0, "dec");
        chk("dec_16", 32'(err_cnt[7:0]), 32'd1);
        repeat (16) step(1'b0, 3'b000, 1'b0, 1'b0, "dec");
        chk("dec_32", 32'(err_cnt[7:0]), 32'd0);
        repeat (16) step(1'b0, 3'b000, 1'b0, 1'b0, "dec");
        chk("dec_floor", 32'(err_cnt[7:0]), 32'd0);
`else
        reset_dut();
        repeat (2) step(1'b1, 3'b001, 1'b0, 1'b0, "hold");
        repeat (40) step(1'b0, 3'b000, 1'b0, 1'b0, "hold");
        chk("hold_cnt", 32'(err_cnt[7:0]), 32'd2);
`endif

        for (int blk = 0; blk < 4; blk++) begin
            reset_dut();
            for (int n = 0; n < 800; n++) begin
                r = int'($urandom_range(0, 99));
                if (r < 45)      re = 3'(1 << $urandom_range(0, 2));
                else if (r < 48) re = 3'b111;
                else if (r < 58) re = 3'b111 & ~3'(1 << $urandom_range(0, 2));
                else             re = 3'b000;
                rev  = ($urandom_range(0, 3) != 0);
                rack = ($urandom_range(0, 9) == 0);
                rclr = ($urandom_range(0, 7) == 0);
                step(rev, re, rack, rclr, "rnd");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
